// File: rtl/priority_decoder_reassembler.sv
// rtl/priority_decoder_reassembler.sv - rebuilds a request vector from a lowest-first set-bit position stream.
// Beats are OR-decoded into acc; a closing beat loads the registered output and holds it until taken.
module priority_decoder_reassembler #(
  parameter int WIDTH = 4,
  parameter int POS_W = $clog2(WIDTH)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [POS_W-1:0]   in_pos,
  input  logic               in_last,
  input  logic               in_empty,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out_vec,
  output logic [POS_W:0]     out_cnt,
  output logic               out_err
);

  typedef enum logic {ACCUM, HOLD} state_t;

  localparam logic [POS_W:0] WIDTH_V = (POS_W+1)'(WIDTH);

  state_t             state;
  logic [WIDTH-1:0]   acc, nxt_acc, bit_hot;
  logic [POS_W:0]     cnt, nxt_cnt;
  logic [POS_W-1:0]   prev_pos, nxt_prev;
  logic               first, nxt_first;
  logic               err, nxt_err;
  logic               close, in_range;

  assign in_ready = (state == ACCUM) && !rst;
  assign in_range = {1'b0, in_pos} < WIDTH_V;
  assign bit_hot  = WIDTH'(1) << in_pos;

  // Frame state as it would be after accepting the current beat.
  always_comb begin
    nxt_acc   = acc;
    nxt_cnt   = cnt;
    nxt_err   = err;
    nxt_prev  = prev_pos;
    nxt_first = first;
    close     = in_last;
    if (in_empty) begin
      close = 1'b1;
      if (!first) nxt_err = 1'b1;
    end else if (!in_range) begin
      nxt_err = 1'b1;
    end else begin
      nxt_acc = acc | bit_hot;
      if ((acc & bit_hot) == '0) nxt_cnt = cnt + (POS_W+1)'(1);
      if (!first && (in_pos <= prev_pos)) nxt_err = 1'b1;
      nxt_prev  = in_pos;
      nxt_first = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ACCUM;
      acc       <= '0;
      cnt       <= '0;
      err       <= 1'b0;
      first     <= 1'b1;
      prev_pos  <= '0;
      out_valid <= 1'b0;
      out_vec   <= '0;
      out_cnt   <= '0;
      out_err   <= 1'b0;
    end else begin
      case (state)
        ACCUM: begin
          if (in_valid) begin
            acc      <= nxt_acc;
            cnt      <= nxt_cnt;
            err      <= nxt_err;
            prev_pos <= nxt_prev;
            first    <= nxt_first;
            if (close) begin
              out_vec   <= nxt_acc;
              out_cnt   <= nxt_cnt;
              out_err   <= nxt_err;
              out_valid <= 1'b1;
              state     <= HOLD;
            end
          end
        end
        HOLD: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            acc       <= '0;
            cnt       <= '0;
            err       <= 1'b0;
            first     <= 1'b1;
            state     <= ACCUM;
          end
        end
        default: state <= ACCUM;
      endcase
    end
  end

endmodule

// File: tb/tb_priority_decoder_reassembler.sv
// tb/tb_priority_decoder_reassembler.sv - scoreboard bench for the position-stream reassembler.
module tb_priority_decoder_reassembler;

  typedef struct {
    logic [3:0] vec;
    logic [2:0] cnt;
    logic       err;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid, in_last, in_empty, out_ready;
  logic [1:0] in_pos;
  logic       in_ready, out_valid, out_err;
  logic [3:0] out_vec;
  logic [2:0] out_cnt;

  logic       in_valid5, in_last5, in_empty5, out_ready5;
  logic [2:0] in_pos5;
  logic       in_ready5, out_valid5, out_err5;
  logic [4:0] out_vec5;
  logic [3:0] out_cnt5;

  exp_t q[$];
  exp_t e;
  int   errors = 0;
  int   checks = 0;

  priority_decoder_reassembler #(.WIDTH(4), .POS_W(2)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_pos(in_pos), .in_last(in_last), .in_empty(in_empty),
    .out_valid(out_valid), .out_ready(out_ready), .out_vec(out_vec),
    .out_cnt(out_cnt), .out_err(out_err)
  );

  priority_decoder_reassembler #(.WIDTH(5), .POS_W(3)) dut5 (
    .clk(clk), .rst(rst), .in_valid(in_valid5), .in_ready(in_ready5),
    .in_pos(in_pos5), .in_last(in_last5), .in_empty(in_empty5),
    .out_valid(out_valid5), .out_ready(out_ready5), .out_vec(out_vec5),
    .out_cnt(out_cnt5), .out_err(out_err5)
  );

  always #5 clk = ~clk;

  // Every completed handshake is matched against the oldest expected frame.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected: got vec=%b cnt=%0d err=%b, required no output", out_vec, out_cnt, out_err);
      end else begin
        e = q.pop_front();
        if (out_vec !== e.vec || out_cnt !== e.cnt || out_err !== e.err) begin
          errors++;
          $display("FAIL sb_frame: got vec=%b cnt=%0d err=%b, required vec=%b cnt=%0d err=%b",
                   out_vec, out_cnt, out_err, e.vec, e.cnt, e.err);
        end
      end
    end
  end

  task automatic push(input logic [3:0] v, input logic [2:0] c, input logic er);
    exp_t x;
    x.vec = v; x.cnt = c; x.err = er;
    q.push_back(x);
  endtask

  // Called at posedge+1; presents one beat for exactly one clock.
  task automatic drive(input logic [1:0] pos, input logic last, input logic empty);
    in_valid = 1'b1; in_pos = pos; in_last = last; in_empty = empty;
    @(posedge clk); #1;
    in_valid = 1'b0; in_last = 1'b0; in_empty = 1'b0;
  endtask

  task automatic finish_frame();
    @(negedge clk);
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    in_valid = 0; in_pos = 0; in_last = 0; in_empty = 0; out_ready = 0;
    in_valid5 = 0; in_pos5 = 0; in_last5 = 0; in_empty5 = 0; out_ready5 = 0;
    repeat (2) @(negedge clk);
    checks++;
    if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready: got %b, required 0", in_ready); end
    checks++;
    if ({out_valid, out_vec, out_cnt, out_err} !== 9'd0) begin
      errors++;
      $display("FAIL reset_outputs: got valid=%b vec=%b cnt=%0d err=%b, required all 0", out_valid, out_vec, out_cnt, out_err);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_release_ready: got %b, required 1", in_ready); end
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    out_ready = 1'b1;
    push(4'b1101, 3'd3, 1'b0);
    drive(2'd0, 0, 0);
    drive(2'd2, 0, 0);
    drive(2'd3, 1, 0);
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL basic_latency: got valid=%b in_ready=%b, required valid=1 in_ready=0", out_valid, in_ready);
    end
    @(posedge clk); #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL basic_release: got valid=%b in_ready=%b, required valid=0 in_ready=1", out_valid, in_ready);
    end
  endtask

  task automatic test_empty();
    push(4'b0000, 3'd0, 1'b0);
    drive(2'd3, 0, 1);
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1) begin errors++; $display("FAIL empty_close: got valid=%b, required 1", out_valid); end
    @(posedge clk); #1;
  endtask

  task automatic test_order();
    push(4'b0110, 3'd2, 1'b1);
    drive(2'd2, 0, 0);
    drive(2'd1, 1, 0);
    finish_frame();
    push(4'b0010, 3'd1, 1'b1);
    drive(2'd1, 0, 0);
    drive(2'd1, 1, 0);
    finish_frame();
    push(4'b0001, 3'd1, 1'b1);
    drive(2'd0, 0, 0);
    drive(2'd0, 0, 1);
    finish_frame();
  endtask

  task automatic test_hold();
    out_ready = 1'b0;
    push(4'b1010, 3'd2, 1'b0);
    drive(2'd1, 0, 0);
    drive(2'd3, 1, 0);
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; in_pos = 2'd0; in_last = 1'b1;
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b1 || out_vec !== 4'b1010 || in_ready !== 1'b0) begin
        errors++;
        $display("FAIL hold_cycle%0d: got valid=%b vec=%b in_ready=%b, required valid=1 vec=1010 in_ready=0",
                 i, out_valid, out_vec, in_ready);
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0; in_last = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    @(posedge clk); #1;
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL hold_drop: got valid=%b, required 0", out_valid); end
    push(4'b0100, 3'd1, 1'b0);
    drive(2'd2, 1, 0);
    finish_frame();
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b1;
    drive(2'd0, 0, 0);
    drive(2'd1, 0, 0);
    #2 rst = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_now: got in_ready=%b valid=%b, required 0 0", in_ready, out_valid);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    push(4'b1000, 3'd1, 1'b0);
    drive(2'd3, 1, 0);
    finish_frame();
    out_ready = 1'b0;
    drive(2'd2, 1, 0);
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1) begin errors++; $display("FAIL rsthold_pre: got valid=%b, required 1", out_valid); end
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({out_valid, out_vec, out_cnt, out_err} !== 9'd0) begin
      errors++;
      $display("FAIL rsthold_now: got valid=%b vec=%b cnt=%0d err=%b, required all 0", out_valid, out_vec, out_cnt, out_err);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    out_ready = 1'b1;
  endtask

  task automatic test_back_to_back();
    logic [3:0] v;
    out_ready = 1'b1;
    for (int f = 0; f < 8; f++) begin
      v = 4'($urandom_range(1, 15));
      push(v, 3'($countones(v)), 1'b0);
      for (int i = 0; i < 4; i++) begin
        if (v[i]) drive(2'(i), ((v >> (i + 1)) == 4'd0), 0);
      end
      finish_frame();
    end
  endtask

  task automatic test_width5();
    out_ready5 = 1'b1;
    in_valid5 = 1'b1; in_pos5 = 3'd1; in_last5 = 1'b0;
    @(posedge clk); #1;
    in_pos5 = 3'd6; in_last5 = 1'b1;
    @(posedge clk); #1;
    in_valid5 = 1'b0; in_last5 = 1'b0;
    @(negedge clk);
    checks++;
    if (out_valid5 !== 1'b1 || out_vec5 !== 5'b00010 || out_cnt5 !== 4'd1 || out_err5 !== 1'b1) begin
      errors++;
      $display("FAIL w5_range: got valid=%b vec=%b cnt=%0d err=%b, required valid=1 vec=00010 cnt=1 err=1",
               out_valid5, out_vec5, out_cnt5, out_err5);
    end
    @(posedge clk); #1;
    checks++;
    if (out_valid5 !== 1'b0) begin errors++; $display("FAIL w5_release: got valid=%b, required 0", out_valid5); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_empty();
    test_order();
    test_hold();
    test_reset_mid();
    test_back_to_back();
    test_width5();
    repeat (3) @(posedge clk);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL sb_drain: got %0d pending frames, required 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/priority_decoder_reassembler.md
# priority_decoder_reassembler

Receive end of the set-bit position stream produced by iterating our 4-bit priority encoder: each beat carries the position of one set bit, lowest first. The block rebuilds the original vector by OR-ing one-hot decodes of each position, then presents the completed vector on a valid/ready output. It validates ordering and range, and flags malformed frames. It sits between the serialized request channel and the arbitration/grant logic that consumes full request vectors.

## Interface
- WIDTH, default 4: reconstructed vector width, at least 2.
- POS_W, default $clog2(WIDTH): width of the position field.
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  reset, asynchronous, active-high.
- in_valid  input  1  input beat present.
- in_ready  output  1  block accepts a beat this cycle.
- in_pos  input  POS_W  position of one set bit.
- in_last  input  1  final beat of the frame.
- in_empty  input  1  frame encodes an all-zero vector; `in_pos` is ignored.
- out_valid  output  1  reconstructed vector available.
- out_ready  input  1  consumer takes the vector.
- out_vec  output  WIDTH  reconstructed vector.
- out_cnt  output  POS_W+1  number of distinct in-range bits set in `out_vec`.
- out_err  output  1  frame violated the protocol; `out_vec` is still delivered.

## Operation
- States:
  - ACCUM: collecting beats.
  - HOLD: output valid, waiting on consumer.
- `in_ready` = (state==ACCUM) and not `rst`.
- A beat is accepted when `in_valid` and `in_ready` are both high.
- Registers: `acc` (WIDTH), `cnt`, `prev_pos`, `first` (frame-start flag), `err` (sticky per frame).
- Accepted beat with `in_empty`=0 and `in_pos` < WIDTH:
  - `acc` |= 1<<`in_pos`.
  - If not `first` and `in_pos` <= `prev_pos`, set `err`. A duplicate does not increment `cnt`; an out-of-order new bit does.
  - Update `prev_pos`; clear `first`.
- `in_pos` >= WIDTH (only possible when WIDTH is not a power of 2): set `err`, bit dropped, `cnt` unchanged.
- `in_empty`=1 on the first beat: frame closes immediately as the zero vector, `in_last` is ignored, `err`=0.
- `in_empty`=1 on a later beat: set `err`, frame closes with the bits accumulated so far.
- Frame close (beat accepted with `in_last`=1, or an `in_empty` beat):
  - Load `out_vec`, `out_cnt` and `out_err` from the values including that beat.
  - Set `out_valid`; go to HOLD.
- HOLD:
  - `out_valid`=1; `out_vec`, `out_cnt` and `out_err` stable.
  - When `out_ready`=1: `out_valid` goes to 0 next cycle, `acc`/`cnt`/`err` cleared, `first`=1, return to ACCUM.
- `out_ready` is ignored while `out_valid`=0.
- `in_*` inputs are ignored while `in_ready`=0.

## Timing
- Reset (asynchronous assert, takes effect immediately):
  - state=ACCUM; `out_valid`=0, `out_vec`=0, `out_cnt`=0, `out_err`=0.
  - `acc`=0, `cnt`=0, `err`=0, `first`=1, `prev_pos`=0.
  - `in_ready`=0 while `rst` is high.
- Reset mid-frame or in HOLD discards all partial state; no output is produced for that frame.
- Latency: `out_valid` rises on the clock edge that accepts the closing beat, i.e. visible the cycle after that beat.
- Throughput: a k-beat frame takes at least k+1 cycles; no input is accepted in HOLD, so there is no same-cycle close/accept overlap.
- `in_ready` is combinational from state only and never depends on `in_valid`.
- `out_vec` is registered; no combinational path from `in_*` to `out_*`.

## Test plan
- Reset, then beats pos=0, pos=2, pos=3(last) on consecutive cycles, `out_ready`=1 -> `out_valid` the cycle after the third beat, `out_vec`=4'b1101, `out_cnt`=3, `out_err`=0; `in_ready` returns 1 the following cycle.
- Single beat `in_empty`=1, `in_last`=0 -> `out_vec`=0, `out_cnt`=0, `out_err`=0.
- Beats pos=2, pos=1(last) -> `out_vec`=4'b0110, `out_cnt`=2, `out_err`=1. Beats pos=1, pos=1(last) -> `out_vec`=4'b0010, `out_cnt`=1, `out_err`=1.
- Frame closes with `out_ready`=0 for 5 cycles -> `out_valid` and `out_vec` held, `in_ready`=0 and input beats ignored; raise `out_ready` -> `out_valid` drops next cycle.
- Beats pos=0, pos=1, assert `rst` asynchronously mid-cycle, release, then send pos=3(last) -> outputs zero immediately on `rst`; the next frame gives `out_vec`=4'b1000, `out_cnt`=1, `out_err`=0.
- WIDTH=5, POS_W=3: beats pos=1, pos=6(last) -> `out_vec`=5'b00010, `out_cnt`=1, `out_err`=1.
